program_loader: RTL and testbench

Serial instruction loader that writes programs into the 16-word instruction ROM that the control unit fetches from. It accepts a framed byte stream over a valid/ready handshake, assembles 16-bit instruction words, writes them to consecutive ROM addresses, and validates an 8-bit checksum. It holds the CPU core in reset while a load is in progress and releases it only after a load completes with a valid checksum.

---
 rtl/program_loader.sv | 130 +++++++++++++
 tb/tb_program_loader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Serial program loader: frames a byte stream into 16-bit words, writes them to the
// instruction ROM and holds the core in reset until a load passes its checksum.
module program_loader #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 8,
   parameter logic [7:0]  SYNC   = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      StIdle, StCount, StHi, StLo, StWrite, StCheck, StDone, StErr
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        sum_q, sum_d;
   logic [7:0]        hi_q, hi_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              xfer;

   assign xfer = in_valid && in_ready;

   // State and datapath registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         count_q <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         sum_q   <= '0;
         hi_q    <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         sum_q   <= sum_d;
         hi_q    <= hi_d;
         wdata_q <= wdata_d;
      end
   end

   // Frame parser: next state, running checksum, word assembly.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      sum_d   = sum_q;
      hi_d    = hi_q;
      wdata_d = wdata_q;
      case (state_q)
         StIdle, StDone, StErr: begin
            // Anything other than SYNC is swallowed while waiting for a frame.
            if (xfer && in_data == SYNC) begin
               state_d = StCount;
               sum_d   = '0;
               idx_d   = '0;
            end
         end
         StCount: begin
            if (xfer) begin
               if (in_data == 8'd0 || 32'(in_data) > DEPTH) begin
                  state_d = StErr;
               end else begin
                  count_d = ADDR_W'(in_data);
                  sum_d   = in_data;
                  state_d = StHi;
               end
            end
         end
         StHi: begin
            if (xfer) begin
               hi_d    = in_data;
               sum_d   = sum_q + in_data;
               state_d = StLo;
            end
         end
         StLo: begin
            if (xfer) begin
               sum_d   = sum_q + in_data;
               addr_d  = idx_q;
               wdata_d = {hi_q, in_data};
               state_d = StWrite;
            end
         end
         StWrite: begin
            // Index stops at the last word so it never points past the ROM.
            if (idx_q == count_q - ADDR_W'(1)) begin
               state_d = StCheck;
            end else begin
               idx_d   = idx_q + ADDR_W'(1);
               state_d = StHi;
            end
         end
         StCheck: begin
            if (xfer) begin
               state_d = (in_data == sum_q) ? StDone : StErr;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from state; rst masks strobes in the cycle it is asserted.
   always_comb begin
      in_ready  = !rst && (state_q != StWrite);
      mem_we    = !rst && (state_q == StWrite);
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      cpu_rst   = rst || (state_q != StDone);
      done      = !rst && (state_q == StDone);
      err       = !rst && (state_q == StErr);
   end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected ROM writes are queued as frames are
// sent and retired by a write monitor on the falling edge.
module tb_program_loader;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              cpu_rst;
   logic              done;
   logic              err;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   logic [23:0] sb[$];
   logic [23:0] mon_exp;
   logic [15:0] fw [DEPTH];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SYNC(8'hA5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_rst   (cpu_rst),
      .done      (done),
      .err       (err)
   );

   // Write monitor: every strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_ready: in_ready=%b required 0", in_ready);
         end
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%0d data=%h required no write",
                     mem_addr, mem_wdata);
         end else begin
            mon_exp = sb.pop_front();
            if ({mem_addr, mem_wdata} !== mon_exp) begin
               errors++;
               $display("FAIL write_data: addr=%0d data=%h required addr=%0d data=%h",
                        mem_addr, mem_wdata, mon_exp[23:16], mon_exp[15:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n;
      if (gaps) begin
         n = 0;
         while ($urandom_range(0, 1) == 0 && n < 4) begin
            in_valid = 1'b0;
            in_data  = 8'(($urandom));
            @(posedge clk); #1;
            n++;
         end
      end
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic load_frame(input int n, input logic [7:0] chk, input bit gaps);
      send_byte(8'hA5, gaps);
      send_byte(8'(n), gaps);
      for (int i = 0; i < n; i++) begin
         sb.push_back({8'(i), fw[i]});
         send_byte(fw[i][15:8], gaps);
         send_byte(fw[i][7:0], gaps);
      end
      send_byte(chk, gaps);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, mem_we} !== 2'b00) begin
         errors++;
         $display("FAIL reset_active: ready,we=%b required 00", {in_ready, mem_we});
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({done, err, cpu_rst} !== 3'b001) begin
         errors++;
         $display("FAIL reset_status: done,err,cpu_rst=%b required 001", {done, err, cpu_rst});
      end
      checks++;
      if ({mem_addr, mem_wdata} !== 24'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mem: addr=%h data=%h ready=%b required 0 0 1",
                  mem_addr, mem_wdata, in_ready);
      end
   endtask

   task automatic test_good_load();
      int c0;
      fw[0] = 16'h1234;
      fw[1] = 16'hABCD;
      c0 = cyc;
      load_frame(2, 8'hC0, 1'b0);
      checks++;
      if (cyc - c0 != 9) begin
         errors++;
         $display("FAIL good_cycles: cycles=%0d required 9", cyc - c0);
      end
      checks++;
      if ({done, err, cpu_rst} !== 3'b100) begin
         errors++;
         $display("FAIL good_status: done,err,cpu_rst=%b required 100", {done, err, cpu_rst});
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL good_writes: pending=%0d required 0", sb.size());
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({mem_addr, mem_wdata} !== {8'd1, 16'hABCD}) begin
         errors++;
         $display("FAIL good_hold: addr=%0d data=%h required 1 abcd", mem_addr, mem_wdata);
      end
   endtask

   task automatic test_bad_checksum();
      fw[0] = 16'h1234;
      fw[1] = 16'hABCD;
      load_frame(2, 8'hC1, 1'b0);
      checks++;
      if ({done, err, cpu_rst} !== 3'b011) begin
         errors++;
         $display("FAIL bad_status: done,err,cpu_rst=%b required 011", {done, err, cpu_rst});
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL bad_writes: pending=%0d required 0", sb.size());
      end
   endtask

   task automatic test_noise();
      fw[0] = 16'h1234;
      fw[1] = 16'hABCD;
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      checks++;
      if ({done, err, cpu_rst} !== 3'b011) begin
         errors++;
         $display("FAIL noise_ignored: done,err,cpu_rst=%b required 011", {done, err, cpu_rst});
      end
      load_frame(2, 8'hC0, 1'b1);
      checks++;
      if ({done, err, cpu_rst} !== 3'b100 || sb.size() != 0) begin
         errors++;
         $display("FAIL noise_status: done,err,cpu_rst=%b pending=%0d required 100 0",
                  {done, err, cpu_rst}, sb.size());
      end
   endtask

   task automatic test_illegal_count();
      logic [7:0] bad [2];
      bad[0] = 8'h00;
      bad[1] = 8'h11;
      fw[0] = 16'h1234;
      fw[1] = 16'hABCD;
      for (int k = 0; k < 2; k++) begin
         send_byte(8'hA5, 1'b0);
         send_byte(bad[k], 1'b0);
         checks++;
         if ({done, err, cpu_rst} !== 3'b011) begin
            errors++;
            $display("FAIL illegal_%0h: done,err,cpu_rst=%b required 011", bad[k],
                     {done, err, cpu_rst});
         end
         load_frame(2, 8'hC0, 1'b0);
         checks++;
         if ({done, err, cpu_rst} !== 3'b100) begin
            errors++;
            $display("FAIL illegal_recover: done,err,cpu_rst=%b required 100",
                     {done, err, cpu_rst});
         end
      end
   endtask

   task automatic test_full_depth();
      for (int i = 0; i < 16; i++) fw[i] = 16'(i);
      load_frame(16, 8'h88, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if ({done, err, cpu_rst} !== 3'b100 || sb.size() != 0) begin
         errors++;
         $display("FAIL full_status: done,err,cpu_rst=%b pending=%0d required 100 0",
                  {done, err, cpu_rst}, sb.size());
      end
      checks++;
      if ({mem_addr, mem_wdata} !== {8'd15, 16'h000F}) begin
         errors++;
         $display("FAIL full_last: addr=%0d data=%h required 15 000f", mem_addr, mem_wdata);
      end
   endtask

   task automatic test_reset_mid_frame();
      fw[0] = 16'h1234;
      fw[1] = 16'hABCD;
      send_byte(8'hA5, 1'b0);
      checks++;
      if ({done, cpu_rst} !== 2'b01) begin
         errors++;
         $display("FAIL reload_rst: done,cpu_rst=%b required 01", {done, cpu_rst});
      end
      send_byte(8'h02, 1'b0);
      sb.push_back({8'd0, 16'h1234});
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      send_byte(8'hAB, 1'b0);
      rst = 1'b1;
      #1;
      checks++;
      if ({in_ready, mem_we} !== 2'b00) begin
         errors++;
         $display("FAIL midrst_active: ready,we=%b required 00", {in_ready, mem_we});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++;
      if ({done, err, cpu_rst, in_ready} !== 4'b0011 || {mem_addr, mem_wdata} !== 24'h0) begin
         errors++;
         $display("FAIL midrst_state: done,err,cpu_rst,ready=%b addr=%h data=%h required 0011 0 0",
                  {done, err, cpu_rst, in_ready}, mem_addr, mem_wdata);
      end
      send_byte(8'hCD, 1'b0);
      send_byte(8'hC0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({done, err, cpu_rst} !== 3'b001 || sb.size() != 0) begin
         errors++;
         $display("FAIL midrst_idle: done,err,cpu_rst=%b pending=%0d required 001 0",
                  {done, err, cpu_rst}, sb.size());
      end
      load_frame(2, 8'hC0, 1'b0);
      checks++;
      if ({done, err, cpu_rst} !== 3'b100 || sb.size() != 0) begin
         errors++;
         $display("FAIL midrst_reload: done,err,cpu_rst=%b pending=%0d required 100 0",
                  {done, err, cpu_rst}, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_good_load();
      test_bad_checksum();
      test_noise();
      test_illegal_count();
      test_full_depth();
      test_reset_mid_frame();
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL final_pending: pending=%0d required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
